// File: rtl/des_pkg.sv
// Shared DES definitions: data/key widths and the load-controller state encoding.
package des_pkg;

  localparam int DES_BLOCK_W = 64;
  localparam int DES_KEY_W   = 64;

  // Width of the inline latency counter; holds any core latency from 1 to 15.
  localparam int LAT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } des_state_e;

endpackage

// File: rtl/des_load_ctrl.sv
// DES load controller: accepts one block/key pair at a time, pulses the core,
// waits a fixed core latency, captures the result and holds it until taken.
module des_load_ctrl
  import des_pkg::*;
#(
  parameter int CORE_LATENCY = 2,
  parameter int CNT_W        = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DES_BLOCK_W-1:0] in_data,
  input  logic [DES_KEY_W-1:0]   in_key,
  output logic                   core_load,
  output logic [DES_BLOCK_W-1:0] core_data,
  output logic [DES_KEY_W-1:0]   core_key,
  input  logic [DES_BLOCK_W-1:0] core_result,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DES_BLOCK_W-1:0] out_data,
  output logic                   busy,
  output logic [CNT_W-1:0]       block_count
);

  // Counter start value; CORE_LATENCY must lie in 1..15 to fit the counter.
  localparam logic [LAT_CNT_W-1:0] LAT_INIT = LAT_CNT_W'(CORE_LATENCY);

  des_state_e             r_state;
  des_state_e             w_nextState;
  logic [LAT_CNT_W-1:0]   r_latCnt;
  logic [DES_BLOCK_W-1:0] r_coreData;
  logic [DES_KEY_W-1:0]   r_coreKey;
  logic [DES_BLOCK_W-1:0] r_outData;
  logic [CNT_W-1:0]       r_blockCount;

  logic w_accept;
  logic w_startCnt;
  logic w_capture;
  logic w_handshake;

  // Next-state decode plus the one-cycle strobes that drive the datapath registers.
  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    w_startCnt  = 1'b0;
    w_capture   = 1'b0;
    w_handshake = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_accept    = 1'b1;
          w_nextState = LOAD;
        end
      end
      LOAD: begin
        w_startCnt  = 1'b1;
        w_nextState = WAIT;
      end
      WAIT: begin
        // A count of 1 marks cycle L+CORE_LATENCY, the one cycle the core result is valid.
        if (r_latCnt <= LAT_CNT_W'(1)) begin
          w_capture   = 1'b1;
          w_nextState = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          w_handshake = 1'b1;
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // State register; reset abandons whatever block is in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Latency counter: loaded while the core is pulsed, counts down through WAIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_latCnt <= '0;
    end else if (w_startCnt) begin
      r_latCnt <= LAT_INIT;
    end else if (r_state == WAIT && r_latCnt != '0) begin
      r_latCnt <= r_latCnt - LAT_CNT_W'(1);
    end
  end

  // Block/key presented to the core; only changes on an IDLE acceptance.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_coreData <= '0;
      r_coreKey  <= '0;
    end else if (w_accept) begin
      r_coreData <= in_data;
      r_coreKey  <= in_key;
    end
  end

  // Result register; stays put through HOLD no matter what the core does.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_outData <= '0;
    end else if (w_capture) begin
      r_outData <= core_result;
    end
  end

  // Completed-handshake counter; wraps naturally at its width.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_blockCount <= '0;
    end else if (w_handshake) begin
      r_blockCount <= r_blockCount + CNT_W'(1);
    end
  end

  assign in_ready    = (r_state == IDLE);
  assign core_load   = (r_state == LOAD);
  assign out_valid   = (r_state == HOLD);
  assign busy        = (r_state != IDLE);
  assign core_data   = r_coreData;
  assign core_key    = r_coreKey;
  assign out_data    = r_outData;
  assign block_count = r_blockCount;

endmodule

// File: tb/tb_des_load_ctrl.sv
// Self-checking bench for des_load_ctrl: three instances (latency 2/1/15),
// a cycle-exact core model and a transaction-level expectation model.
module tb_des_load_ctrl;

  localparam int NI = 3;

  logic clk = 1'b0;
  logic reset;

  logic        inValid    [NI];
  logic [63:0] inData     [NI];
  logic [63:0] inKey      [NI];
  logic        outReady   [NI];
  logic        inReady    [NI];
  logic        coreLoad   [NI];
  logic [63:0] coreData   [NI];
  logic [63:0] coreKey    [NI];
  logic [63:0] coreResult [NI];
  logic        outValid   [NI];
  logic [63:0] outData    [NI];
  logic        busyS      [NI];
  logic [15:0] blockCount [NI];

  int cyc = 0;
  int lastLoad  [NI];
  bit haveLoad  [NI];
  int loadN     [NI];
  int loadTimes [NI][64];

  int expCount [NI];
  int errors;
  int checks;

  always #5 clk = ~clk;

  function automatic int latOf(input int g);
    case (g)
      0:       return 2;
      1:       return 1;
      default: return 15;
    endcase
  endfunction

  function automatic int cwOf(input int g);
    return (g == 0) ? 16 : 4;
  endfunction

  // Stand-in for the DES transform; the known answer vector is honoured exactly.
  function automatic logic [63:0] coreFn(input logic [63:0] d, input logic [63:0] k);
    if (d == 64'h0123456789ABCDEF && k == 64'h133457799BBCDFF1)
      return 64'h85E813540F0AB405;
    return {d[40:0], d[63:41]} ^ k ^ 64'h5A5A0F0F3C3C9696;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : gDut
    localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 15);
    localparam int CW  = (g == 0) ? 16 : 4;
    logic [CW-1:0] bc;
    des_load_ctrl #(.CORE_LATENCY(LAT), .CNT_W(CW)) uDut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (inValid[g]),
      .in_ready   (inReady[g]),
      .in_data    (inData[g]),
      .in_key     (inKey[g]),
      .core_load  (coreLoad[g]),
      .core_data  (coreData[g]),
      .core_key   (coreKey[g]),
      .core_result(coreResult[g]),
      .out_valid  (outValid[g]),
      .out_ready  (outReady[g]),
      .out_data   (outData[g]),
      .busy       (busyS[g]),
      .block_count(bc)
    );
    assign blockCount[g] = 16'(bc);
  end

  // Cycle index plus a record of every cycle in which a core was pulsed.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int g = 0; g < NI; g++) begin
      if (coreLoad[g]) begin
        lastLoad[g] <= cyc;
        haveLoad[g] <= 1'b1;
        if (loadN[g] < 64) loadTimes[g][loadN[g]] <= cyc;
        loadN[g] <= loadN[g] + 1;
      end
    end
  end

  // Core model: the correct result appears only in cycle L+latency, garbage otherwise.
  always_comb begin
    for (int g = 0; g < NI; g++) begin
      coreResult[g] = ~coreFn(coreData[g], coreKey[g]);
      if (haveLoad[g] && cyc == lastLoad[g] + latOf(g))
        coreResult[g] = coreFn(coreData[g], coreKey[g]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkResetValues(input int g, input string tag);
    checkOutput($sformatf("%s_u%0d_in_ready", tag, g), 64'(inReady[g]), 64'd1);
    checkOutput($sformatf("%s_u%0d_busy", tag, g), 64'(busyS[g]), 64'd0);
    checkOutput($sformatf("%s_u%0d_core_load", tag, g), 64'(coreLoad[g]), 64'd0);
    checkOutput($sformatf("%s_u%0d_out_valid", tag, g), 64'(outValid[g]), 64'd0);
    checkOutput($sformatf("%s_u%0d_out_data", tag, g), outData[g], 64'd0);
    checkOutput($sformatf("%s_u%0d_core_data", tag, g), coreData[g], 64'd0);
    checkOutput($sformatf("%s_u%0d_core_key", tag, g), coreKey[g], 64'd0);
    checkOutput($sformatf("%s_u%0d_block_count", tag, g), 64'(blockCount[g]), 64'd0);
  endtask

  // One complete block: offer, check the pulse and exact capture cycle,
  // stall `hold` cycles in HOLD with junk upstream traffic, then hand off.
  task automatic applyStimulus(input int g, input logic [63:0] d, input logic [63:0] k, input int hold);
    int n;
    int lat;
    logic [63:0] expOut;
    lat = latOf(g);
    expOut = coreFn(d, k);
    inData[g] = d;
    inKey[g] = k;
    inValid[g] = 1'b1;
    n = 0;
    while (!inReady[g] && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) checkOutput($sformatf("u%0d_accept_timeout", g), 64'(inReady[g]), 64'd1);
    step();
    inValid[g] = 1'b0;
    checkOutput($sformatf("u%0d_core_load_pulse", g), 64'(coreLoad[g]), 64'd1);
    checkOutput($sformatf("u%0d_core_data", g), coreData[g], d);
    checkOutput($sformatf("u%0d_core_key", g), coreKey[g], k);
    for (int i = 1; i <= lat; i++) begin
      step();
      checkOutput($sformatf("u%0d_load_low_%0d", g, i), 64'(coreLoad[g]), 64'd0);
      checkOutput($sformatf("u%0d_early_valid_%0d", g, i), 64'(outValid[g]), 64'd0);
    end
    step();
    checkOutput($sformatf("u%0d_out_valid", g), 64'(outValid[g]), 64'd1);
    checkOutput($sformatf("u%0d_out_data", g), outData[g], expOut);
    checkOutput($sformatf("u%0d_busy_hold", g), 64'(busyS[g]), 64'd1);
    for (int h = 0; h < hold; h++) begin
      inValid[g] = 1'($urandom_range(0, 1));
      inData[g] = {$urandom, $urandom};
      inKey[g] = {$urandom, $urandom};
      step();
      checkOutput($sformatf("u%0d_hold_valid_%0d", g, h), 64'(outValid[g]), 64'd1);
      checkOutput($sformatf("u%0d_hold_data_%0d", g, h), outData[g], expOut);
      checkOutput($sformatf("u%0d_hold_ready_%0d", g, h), 64'(inReady[g]), 64'd0);
      checkOutput($sformatf("u%0d_hold_noload_%0d", g, h), 64'(coreLoad[g]), 64'd0);
      checkOutput($sformatf("u%0d_hold_coredata_%0d", g, h), coreData[g], d);
    end
    inValid[g] = 1'b0;
    outReady[g] = 1'b1;
    step();
    outReady[g] = 1'b0;
    expCount[g] = (expCount[g] + 1) % (1 << cwOf(g));
    checkOutput($sformatf("u%0d_block_count", g), 64'(blockCount[g]), 64'(expCount[g]));
    checkOutput($sformatf("u%0d_valid_dropped", g), 64'(outValid[g]), 64'd0);
    checkOutput($sformatf("u%0d_ready_again", g), 64'(inReady[g]), 64'd1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [63:0] bd [3];
    logic [63:0] bk [3];
    int base;
    int idx;
    int got;
    logic acc;
    logic hs;

    errors = 0;
    checks = 0;
    reset = 1'b1;
    for (int g = 0; g < NI; g++) begin
      inValid[g] = 1'b0;
      inData[g] = '0;
      inKey[g] = '0;
      outReady[g] = 1'b0;
      expCount[g] = 0;
    end
    repeat (3) step();
    reset = 1'b0;
    step();
    for (int g = 0; g < NI; g++) checkResetValues(g, "por");

    // out_ready with nothing to deliver must not count.
    outReady[0] = 1'b1;
    repeat (4) step();
    outReady[0] = 1'b0;
    checkOutput("idle_ready_count", 64'(blockCount[0]), 64'd0);
    checkOutput("idle_ready_valid", 64'(outValid[0]), 64'd0);

    // Known-answer block with a 10-cycle downstream stall.
    applyStimulus(0, 64'h0123456789ABCDEF, 64'h133457799BBCDFF1, 10);
    checkOutput("kat_value", outData[0], 64'h85E813540F0AB405);

    // Back-to-back burst: in_valid held high, out_ready held high.
    for (int i = 0; i < 3; i++) begin
      bd[i] = {$urandom, $urandom};
      bk[i] = {$urandom, 28'h0, 4'(i)};
    end
    base = loadN[0];
    idx = 0;
    got = 0;
    inData[0] = bd[0];
    inKey[0] = bk[0];
    inValid[0] = 1'b1;
    outReady[0] = 1'b1;
    for (int c = 0; c < 60 && got < 3; c++) begin
      acc = inReady[0] & inValid[0];
      hs = outValid[0];
      if (hs) begin
        checkOutput($sformatf("burst_data_%0d", got), outData[0], coreFn(bd[got], bk[got]));
        got++;
        expCount[0] = (expCount[0] + 1) % (1 << 16);
      end
      step();
      if (acc) begin
        idx++;
        if (idx < 3) begin
          inData[0] = bd[idx];
          inKey[0] = bk[idx];
        end else begin
          inValid[0] = 1'b0;
        end
      end
    end
    inValid[0] = 1'b0;
    outReady[0] = 1'b0;
    checkOutput("burst_results", 64'(got), 64'd3);
    checkOutput("burst_loads", 64'(loadN[0] - base), 64'd3);
    for (int i = 1; i < 3; i++)
      checkOutput($sformatf("burst_spacing_%0d", i),
                  64'(loadTimes[0][base + i] - loadTimes[0][base + i - 1]), 64'd5);
    checkOutput("burst_count", 64'(blockCount[0]), 64'(expCount[0]));

    // Reset together with a HOLD handshake: reset wins, nothing is counted.
    inData[0] = {$urandom, $urandom};
    inKey[0] = {$urandom, $urandom};
    inValid[0] = 1'b1;
    step();
    inValid[0] = 1'b0;
    repeat (3) step();
    checkOutput("pre_reset_hold", 64'(outValid[0]), 64'd1);
    outReady[0] = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    outReady[0] = 1'b0;
    expCount[0] = 0;
    checkResetValues(0, "hold_reset");

    // Reset during WAIT abandons the block entirely.
    inData[0] = {$urandom, $urandom};
    inKey[0] = {$urandom, $urandom};
    inValid[0] = 1'b1;
    step();
    inValid[0] = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checkResetValues(0, "wait_reset");
    for (int i = 0; i < 5; i++) begin
      step();
      checkOutput($sformatf("abandoned_valid_%0d", i), 64'(outValid[0]), 64'd0);
    end
    applyStimulus(0, {$urandom, $urandom}, {$urandom, $urandom}, 0);

    // Random traffic with random downstream stalls.
    for (int i = 0; i < 6; i++)
      applyStimulus(0, {$urandom, $urandom}, {$urandom, $urandom}, int'($urandom_range(0, 4)));

    // Latency 1 with a 4-bit counter: 17 blocks wrap the count through 0.
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1, {$urandom, $urandom}, {$urandom, $urandom}, 0);
      if (i == 15) checkOutput("wrap_zero", 64'(blockCount[1]), 64'd0);
    end
    checkOutput("wrap_seventeen", 64'(blockCount[1]), 64'd1);

    // Latency 15: capture must land exactly in cycle L+15.
    for (int i = 0; i < 2; i++)
      applyStimulus(2, {$urandom, $urandom}, {$urandom, $urandom}, int'($urandom_range(0, 2)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/des_load_ctrl.md
DES_LOAD_CTRL -- requirements
Module: des_load_ctrl

Interface
REQ-001 Parameter CORE_LATENCY, default 2: cycles from the core_load cycle to the cycle in which core_result is valid; legal range 1..15.
REQ-002 Parameter CNT_W, default 16: width of block_count.
REQ-003 Port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port in_valid  input  1  upstream block/key pair offered.
REQ-006 Port in_ready  output  1  controller accepts a pair this cycle.
REQ-007 Port in_data  input  64  plaintext block.
REQ-008 Port in_key  input  64  DES key.
REQ-009 Port core_load  output  1  one-cycle start pulse to the DES core.
REQ-010 Port core_data  output  64  block presented to the core.
REQ-011 Port core_key  output  64  key presented to the core.
REQ-012 Port core_result  input  64  DES core data_out.
REQ-013 Port out_valid  output  1  result available downstream.
REQ-014 Port out_ready  input  1  downstream accepts the result.
REQ-015 Port out_data  output  64  captured result.
REQ-016 Port busy  output  1  high whenever state is not IDLE.
REQ-017 Port block_count  output  CNT_W  number of completed output handshakes.

Function
REQ-018 The FSM SHALL have exactly four states: IDLE, LOAD, WAIT, HOLD.
REQ-019 IDLE: in_ready=1; on in_valid=1, register in_data into core_data and in_key into core_key, then go to LOAD.
REQ-020 LOAD: core_load=1 for exactly one cycle (cycle L); load the latency counter with CORE_LATENCY; go to WAIT.
REQ-021 WAIT: decrement the counter each cycle; in cycle L+CORE_LATENCY, register core_result into out_data and go to HOLD.
REQ-022 HOLD: out_valid=1 and out_data stable; on out_ready=1, go to IDLE.
REQ-023 in_ready SHALL be 0 in every state except IDLE, so no new pair is accepted while a block is in flight; there is no bypass path.
REQ-024 Minimum spacing between accepted pairs SHALL be CORE_LATENCY+3 cycles, reached when out_ready is held at 1.
REQ-025 core_load SHALL be 0 in every state other than LOAD.
REQ-026 core_data and core_key SHALL hold their last captured values until the next IDLE acceptance.
REQ-027 block_count SHALL increment by 1 on each HOLD-state out_ready handshake and wrap from 2^CNT_W-1 to 0.
REQ-028 in_valid during LOAD, WAIT, or HOLD SHALL be ignored, with no capture and no side effect.
REQ-029 out_ready while out_valid=0 SHALL be ignored.

Reset
REQ-030 While reset=1 at a clock edge, the block SHALL set: state=IDLE, core_load=0, out_valid=0, out_data=0, core_data=0, core_key=0, block_count=0, counter=0; busy=0, and in_ready=1 from the first cycle after reset.
REQ-031 Reset asserted in LOAD, WAIT, or HOLD SHALL abandon the in-flight block: no out_valid for it and no block_count increment.
REQ-032 Reset SHALL take priority over all handshakes in the same cycle.

Structure
REQ-033 Package des_pkg SHALL hold DES_BLOCK_W=64, DES_KEY_W=64 and the FSM state enum, shared with the DES core and testbenches.
REQ-034 The block SHALL be a single module with no sub-modules; the latency counter is inline.

Verification
REQ-035 Reset, then offer key 133457799BBCDFF1 with data 0123456789ABCDEF against a core model returning 85E813540F0AB405 at latency 2 -> core_load is high for one cycle, out_valid rises 3 cycles after core_load, out_data=85E813540F0AB405, and block_count=1 after the handshake.
REQ-036 Hold out_ready=0 for 10 cycles in HOLD -> out_valid and out_data remain stable, in_ready=0, and no second core_load occurs.
REQ-037 Hold in_valid=1 continuously with three distinct pairs and out_ready=1 -> exactly three core_load pulses spaced 5 cycles apart (CORE_LATENCY=2), results in order, and block_count=3.
REQ-038 Assert reset during WAIT -> no out_valid, all outputs return to their reset values, and the next pair completes normally.
REQ-039 With CNT_W=4, run 17 blocks -> block_count reads 1 and wraps through 0 after the 16th block.
REQ-040 With CORE_LATENCY=1 and CORE_LATENCY=15 -> capture occurs exactly at cycle L+CORE_LATENCY, checked against a core model that presents the correct result only in that cycle.
